// File: rtl/sync_prefetch_fifo.sv
// Single-clock first-word-fall-through FIFO. Storage is a (DEPTH-1)-entry RAM
// plus one output register, so the total capacity is DEPTH. The head word is
// always presented registered on rd_data.
module sync_prefetch_fifo #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 9,
    parameter int AF_LEVEL    = (2 ** DEPTH_WIDTH) - 4,
    parameter int AE_LEVEL    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    output logic                   wr_vld,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    output logic                   rd_vld,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DEPTH_WIDTH:0]   data_cnt,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int DEPTH     = 2 ** DEPTH_WIDTH;
    localparam int RAM_DEPTH = DEPTH - 1;
    localparam int CW        = DEPTH_WIDTH + 1;

    localparam logic [CW-1:0]          DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]          AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0]          AE_C     = CW'(AE_LEVEL);
    localparam logic [DEPTH_WIDTH-1:0] PTR_LAST = DEPTH_WIDTH'(RAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                   af_q, af_d;
    logic                   ae_q, ae_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;

    logic wr_acc;
    logic pop;
    logic ram_has_data;
    logic load;
    logic mem_we;

    // Pointers step through the RAM modulo its (non power-of-two) entry count.
    function automatic logic [DEPTH_WIDTH-1:0] next_ptr(input logic [DEPTH_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshake qualifiers and the prefetch decision.
    always_comb begin
        wr_acc       = wr_en && (cnt_q < DEPTH_C);
        pop          = rd_en && rd_vld_q;
        // RAM occupancy is the total count minus the word held in the output register.
        ram_has_data = cnt_q > {{(CW-1){1'b0}}, rd_vld_q};
        load         = ram_has_data && (!rd_vld_q || pop);
        mem_we       = wr_acc && !flush && !rst;
    end

    // Next-state for pointers, count, output register and flags.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        rd_vld_d  = rd_vld_q;
        rd_data_d = rd_data_q;
        af_d      = af_q;
        ae_d      = ae_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;

        if (flush) begin
            // Contents discarded; the last head word and sticky flags are kept.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            rd_vld_d = 1'b0;
            af_d     = 1'b0;
            ae_d     = 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (load) begin
                rd_ptr_d  = next_ptr(rd_ptr_q);
                rd_vld_d  = 1'b1;
                rd_data_d = mem[rd_ptr_q];
            end else if (pop) begin
                rd_vld_d  = 1'b0;
            end
            case ({wr_acc, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            af_d  = cnt_d >= AF_C;
            ae_d  = cnt_d <= AE_C;
            ovf_d = ovf_q || (wr_en && !wr_acc);
            unf_d = unf_q || (rd_en && !rd_vld_q);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // RAM write port; the output register doubles as the RAM's read register.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array is deliberately not reset so it maps onto memory primitives;
        // validity is tracked by the pointers and count instead.
        if (mem_we) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign wr_vld       = cnt_q < DEPTH_C;
    assign rd_vld       = rd_vld_q;
    assign rd_data      = rd_data_q;
    assign data_cnt     = cnt_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_prefetch_fifo.sv
// Directed bench for sync_prefetch_fifo at DEPTH=16, AF=12, AE=4.
module tb_sync_prefetch_fifo;

    logic        clk = 1'b0;
    logic        rst, flush, wr_en, rd_en;
    logic [15:0] wr_data;
    logic        wr_vld, rd_vld, almost_full, almost_empty, overflow, underflow;
    logic [15:0] rd_data;
    logic [4:0]  data_cnt;

    int errors = 0;
    int checks = 0;

    sync_prefetch_fifo #(
        .DATA_WIDTH (16),
        .DEPTH_WIDTH(4),
        .AF_LEVEL   (12),
        .AE_LEVEL   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_vld      (wr_vld),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_vld      (rd_vld),
        .rd_data     (rd_data),
        .data_cnt    (data_cnt),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, flush, wr_en, rd_en;
        logic [15:0] wr_data;
        logic        rd_vld;
        logic [15:0] rd_data;
        logic [4:0]  cnt;
        logic        wr_vld, af, ae, ovf, unf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, return 1 ns after the edge.
    task automatic step(input logic r, input logic f, input logic w, input logic [15:0] d, input logic rd);
        rst = r; flush = f; wr_en = w; wr_data = d; rd_en = rd;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".rd_vld"},  32'(rd_vld), 0);
        check({tag, ".rd_data"}, 32'(rd_data), 0);
        check({tag, ".cnt"},     32'(data_cnt), 0);
        check({tag, ".wr_vld"},  32'(wr_vld), 1);
        check({tag, ".af"},      32'(almost_full), 0);
        check({tag, ".ae"},      32'(almost_empty), 1);
        check({tag, ".ovf"},     32'(overflow), 0);
        check({tag, ".unf"},     32'(underflow), 0);
    endtask

    initial begin
        vec_t        vecs [13];
        logic [15:0] exp_out;
        logic [15:0] wdata;
        int          pops;

        // rst flush wr  rd  wr_data   rd_vld rd_data  cnt wr_vld af ae ovf unf
        vecs[0]  = '{1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 0, 0};
        vecs[1]  = '{0, 0, 1, 0, 16'h1111, 0, 16'h0000, 1, 1, 0, 1, 0, 0};
        vecs[2]  = '{0, 0, 1, 0, 16'h2222, 1, 16'h1111, 2, 1, 0, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 16'h0000, 1, 16'h1111, 2, 1, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 1, 16'h0000, 1, 16'h2222, 1, 1, 0, 1, 0, 0};
        vecs[5]  = '{0, 0, 1, 1, 16'h3333, 0, 16'h2222, 1, 1, 0, 1, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 16'h0000, 1, 16'h3333, 1, 1, 0, 1, 0, 0};
        vecs[7]  = '{0, 0, 0, 1, 16'h0000, 0, 16'h3333, 0, 1, 0, 1, 0, 0};
        vecs[8]  = '{0, 0, 0, 1, 16'h0000, 0, 16'h3333, 0, 1, 0, 1, 0, 1};
        vecs[9]  = '{0, 0, 1, 1, 16'h4444, 0, 16'h3333, 1, 1, 0, 1, 0, 1};
        vecs[10] = '{0, 1, 1, 0, 16'h5555, 0, 16'h3333, 0, 1, 0, 1, 0, 1};
        vecs[11] = '{0, 0, 0, 0, 16'h0000, 0, 16'h3333, 0, 1, 0, 1, 0, 1};
        vecs[12] = '{1, 0, 1, 1, 16'h6666, 0, 16'h0000, 0, 1, 0, 1, 0, 0};

        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        @(posedge clk);
        #1;

        // Table: short traffic mix covering latency, bubbles, empty corners, flush.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst, vecs[i].flush, vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en);
            check($sformatf("vec%0d.rd_vld", i),  32'(rd_vld),       32'(vecs[i].rd_vld));
            check($sformatf("vec%0d.rd_data", i), 32'(rd_data),      32'(vecs[i].rd_data));
            check($sformatf("vec%0d.cnt", i),     32'(data_cnt),     32'(vecs[i].cnt));
            check($sformatf("vec%0d.wr_vld", i),  32'(wr_vld),       32'(vecs[i].wr_vld));
            check($sformatf("vec%0d.af", i),      32'(almost_full),  32'(vecs[i].af));
            check($sformatf("vec%0d.ae", i),      32'(almost_empty), 32'(vecs[i].ae));
            check($sformatf("vec%0d.ovf", i),     32'(overflow),     32'(vecs[i].ovf));
            check($sformatf("vec%0d.unf", i),     32'(underflow),    32'(vecs[i].unf));
        end

        // Fill to capacity, then overflow.
        step(1, 0, 0, 16'h0, 0);
        check_reset_state("t1.reset");
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 1, 16'(i), 0);
            check($sformatf("t1.cnt%0d", i),    32'(data_cnt),    32'(i));
            check($sformatf("t1.af%0d", i),     32'(almost_full), 32'(i >= 12));
            check($sformatf("t1.wr_vld%0d", i), 32'(wr_vld),      32'(i < 16));
            check($sformatf("t1.rd_vld%0d", i), 32'(rd_vld),      32'(i >= 2));
            if (i >= 2) check($sformatf("t1.head%0d", i), 32'(rd_data), 32'h0001);
        end
        step(0, 0, 1, 16'h0011, 0);
        check("t1.ovf", 32'(overflow), 1);
        check("t1.cnt_full", 32'(data_cnt), 16);

        // Drain in order, then underflow.
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("t2.rd_vld%0d", i), 32'(rd_vld), 1);
            check($sformatf("t2.data%0d", i), 32'(rd_data), 32'(i));
            step(0, 0, 0, 16'h0, 1);
            check($sformatf("t2.cnt%0d", i), 32'(data_cnt), 32'(16 - i));
            check($sformatf("t2.ae%0d", i), 32'(almost_empty), 32'((16 - i) <= 4));
        end
        check("t2.rd_vld_end", 32'(rd_vld), 0);
        check("t2.unf_before", 32'(underflow), 0);
        step(0, 0, 0, 16'h0, 1);
        check("t2.unf", 32'(underflow), 1);

        // Streaming with a sink that pops whenever a word is valid.
        step(1, 0, 0, 16'h0, 0);
        exp_out = 16'h0100;
        wdata   = 16'h0100;
        pops    = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            logic do_rd;
            do_rd = rd_vld;
            if (do_rd) begin
                if (rd_data !== exp_out) begin
                    check($sformatf("t3.data_c%0d", cyc), 32'(rd_data), 32'(exp_out));
                end
                exp_out++;
                pops++;
            end
            step(0, 0, 1, wdata, do_rd);
            wdata++;
            if (cyc >= 2 && data_cnt !== 5'd2) begin
                check($sformatf("t3.cnt_c%0d", cyc), 32'(data_cnt), 2);
            end
        end
        check("t3.pops", 32'(pops), 98);
        check("t3.last", 32'(rd_data), 32'(exp_out));
        check("t3.cnt", 32'(data_cnt), 2);
        check("t3.ovf", 32'(overflow), 0);
        check("t3.unf", 32'(underflow), 0);

        // Full: simultaneous write and pop drops the write.
        step(1, 0, 0, 16'h0, 0);
        for (int i = 1; i <= 16; i++) step(0, 0, 1, 16'(i), 0);
        step(0, 0, 1, 16'hBEEF, 1);
        check("t4.head", 32'(rd_data), 32'h0002);
        check("t4.cnt", 32'(data_cnt), 15);
        check("t4.ovf", 32'(overflow), 1);
        check("t4.wr_vld", 32'(wr_vld), 1);
        for (int i = 2; i <= 16; i++) begin
            check($sformatf("t4.data%0d", i), 32'(rd_data), 32'(i));
            step(0, 0, 0, 16'h0, 1);
        end
        check("t4.empty", 32'(rd_vld), 0);
        check("t4.cnt_end", 32'(data_cnt), 0);

        // Flush at half full keeps sticky overflow and the last head word.
        for (int i = 1; i <= 8; i++) step(0, 0, 1, 16'h0100 + 16'(i), 0);
        check("t5.cnt8", 32'(data_cnt), 8);
        step(0, 1, 1, 16'h7777, 1);
        check("t5.cnt", 32'(data_cnt), 0);
        check("t5.rd_vld", 32'(rd_vld), 0);
        check("t5.rd_data", 32'(rd_data), 32'h0101);
        check("t5.ovf", 32'(overflow), 1);
        check("t5.ae", 32'(almost_empty), 1);
        step(0, 0, 1, 16'h00AA, 0);
        check("t5.lat_vld", 32'(rd_vld), 0);
        step(0, 0, 0, 16'h0, 0);
        check("t5.vld", 32'(rd_vld), 1);
        check("t5.data", 32'(rd_data), 32'h00AA);

        // Reset mid-stream with traffic asserted.
        step(0, 0, 1, 16'h0C01, 1);
        step(0, 0, 1, 16'h0C02, 1);
        step(1, 0, 1, 16'h0C03, 1);
        check_reset_state("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
